vga_out: RTL and testbench
==========================

// Module: vga_out
// PURPOSE
//  Downstream consumer of the VGA frame buffer. Generates 640x480@60 VGA timing from a 25 MHz pixel clock.
//  Drives the frame buffer read pointers (pix_ptr_x/pix_ptr_y), shows the 256x240 NES image 2x-scaled
//  (512x480, centred with a 64-px border each side), and widens the 9-bit RRRGGGBBB pixel to 8 bits/channel for the DAC.
//  Also gives the PPU a vblank level and a frame_start strobe.
// PARAMETERS
//  H_ACTIVE    640    visible pixels per line
//  H_FP        16     horizontal front porch
//  H_SYNC      96     hsync width
//  H_BP        48     horizontal back porch (line total H_TOT=800)
//  V_ACTIVE    480    visible lines
//  V_FP        10     vertical front porch
//  V_SYNC      2      vsync width
//  V_BP        33     vertical back porch (frame total V_TOT=525)
//  X_OFFSET    64     first active column of scaled image (image spans X_OFFSET..X_OFFSET+511)
//  BORDER_RGB  9'h000 RRRGGGBBB shown in visible area outside the image
// PORTS
//  clk          in   1   25 MHz pixel clock
//  rst          in   1   synchronous, active-high reset
//  pix_ptr_x    out  8   fb read column (combinational from stage-0 counters)
//  pix_ptr_y    out  8   fb read row (combinational from stage-0 counters)
//  rgb          in   9   fb pixel RRRGGGBBB, valid same cycle as pix_ptr (async-read fb)
//  vga_r        out  8   red to DAC, registered
//  vga_g        out  8   green to DAC, registered
//  vga_b        out  8   blue to DAC, registered
//  vga_hs       out  1   hsync, active-low, registered
//  vga_vs       out  1   vsync, active-low, registered
//  vga_blank_n  out  1   1 in visible 640x480, registered
//  vblank       out  1   1 while stage-1 line >= V_ACTIVE, registered
//  frame_start  out  1   1-cycle pulse coincident with output pixel (0,0)
// BEHAVIOUR
//  Stage 0: hcnt 0..H_TOT-1, vcnt 0..V_TOT-1 registered, both 10 bit.
//   - hcnt wraps H_TOT-1 -> 0.
//   - vcnt increments only on hcnt wrap; V_TOT-1 -> 0 on hcnt wrap.
//  in_img = (vcnt < V_ACTIVE) && (hcnt >= X_OFFSET) && (hcnt < X_OFFSET+512).
//  pix_ptr_x = in_img ? (hcnt - X_OFFSET)[8:1] : 0
//  pix_ptr_y = in_img ? vcnt[8:1] : 0
//   - Each fb pixel is shown as 2x2; row 239 maps to lines 478/479.
//  Stage 1 (1-cycle latency, all outputs registered from stage-0 values):
//   - vga_hs = !(hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)), i.e. low for hcnt 656..751.
//   - vga_vs = !(vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)), i.e. low for vcnt 490..491, whole lines.
//   - vga_blank_n = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE).
//   - Colour source: in_img ? rgb : (blank_n ? BORDER_RGB : 9'h000).
//   - Expansion: 3b c -> 8b {c,c,c[2:1]}, so 3'b111 -> 8'hFF, 3'b000 -> 8'h00, 3'b100 -> 8'h92.
//   - vblank = (vcnt >= V_ACTIVE).
//   - frame_start = (hcnt==0 && vcnt==0).
//  Reset (sync, any cycle, including mid-line/mid-frame): next edge sets
//   - hcnt=vcnt=0
//   - vga_hs=1, vga_vs=1, vga_blank_n=0, vblank=0, frame_start=0, vga_r/g/b=0
//   - first post-reset cycle outputs pixel (0,0) with frame_start=1.
//  rgb is sampled only when in_img; otherwise ignored (X on rgb must not reach outputs).
//  No back-pressure: timing free-runs; the fb is always readable.
// TESTING
//  1. Reset then run 800*525 cycles -> exactly one frame_start, 525 vga_hs low pulses of 96 cycles, one vga_vs low pulse of 1600 cycles.
//  2. Line 0 -> vga_blank_n high 640 cycles; hs falls 656 cycles after frame_start; next line's pixel 0 at cycle 800.
//  3. fb model with rgb=9'h1FF at (0,0), else 0 -> vga_r/g/b=FF at output hcnt 64,65 on lines 0,1 only; hcnt 63/66 = BORDER.
//  4. rgb=9'b100_010_001 in image -> vga_r=92, vga_g=49, vga_b=24; pix_ptr_x=255 at hcnt 574/575, 0 outside image.
//  5. BORDER_RGB=9'h1C0 -> hcnt 0..63 and 576..639 red FF; hcnt 640..799 and lines >= 480 all 0 with vblank=1.
//  6. Assert rst at hcnt=300, vcnt=200 for 1 cycle -> outputs at reset values next edge, frame_start 1 cycle later, counts restart from 0.

Source files
------------

// File: rtl/vga_out.sv
// 640x480@60 VGA timing generator that scans a 256x240 frame buffer 2x-scaled into a centred
// 512x480 window and widens RRRGGGBBB pixels to 8 bits per channel.
module vga_out #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned X_OFFSET   = 64,
    parameter logic [8:0]  BORDER_RGB = 9'h000
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] pix_ptr_x,
    output logic [7:0] pix_ptr_y,
    input  logic [8:0] rgb,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       vblank,
    output logic       frame_start
);

    localparam int unsigned CW       = 10;
    localparam int unsigned IMG_W    = 512;
    localparam int unsigned H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic [CW-1:0] hcnt;
    logic [CW-1:0] vcnt;
    logic          h_last;
    logic          v_last;
    logic          in_img;
    logic          vis;
    logic          hs_act;
    logic          vs_act;
    logic [8:0]    pix;

    // Replicate the 3-bit channel so full scale maps to 8'hFF.
    function automatic logic [7:0] expand(input logic [2:0] c);
        return {c, c, c[2:1]};
    endfunction

    // Stage 0: free-running raster position.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (h_last) begin
            hcnt <= '0;
            vcnt <= v_last ? '0 : vcnt + CW'(1);
        end else begin
            hcnt <= hcnt + CW'(1);
        end
    end

    always_comb begin
        h_last    = (hcnt == CW'(H_TOT - 1));
        v_last    = (vcnt == CW'(V_TOT - 1));
        in_img    = (vcnt < CW'(V_ACTIVE)) && (hcnt >= CW'(X_OFFSET))
                    && (hcnt < CW'(X_OFFSET + IMG_W));
        vis       = (hcnt < CW'(H_ACTIVE)) && (vcnt < CW'(V_ACTIVE));
        hs_act    = (hcnt >= CW'(HS_START)) && (hcnt < CW'(HS_END));
        vs_act    = (vcnt >= CW'(VS_START)) && (vcnt < CW'(VS_END));
        pix_ptr_x = '0;
        pix_ptr_y = '0;
        if (in_img) begin
            pix_ptr_x = 8'((hcnt - CW'(X_OFFSET)) >> 1);
            pix_ptr_y = vcnt[8:1];
        end
        // rgb only passes through inside the image so an undriven fb bus never reaches the DAC.
        pix = '0;
        if (in_img) begin
            pix = rgb;
        end else if (vis) begin
            pix = BORDER_RGB;
        end
    end

    // Stage 1: every DAC/sync/status output registered off the stage-0 position.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
            vblank      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            vga_r       <= expand(pix[8:6]);
            vga_g       <= expand(pix[5:3]);
            vga_b       <= expand(pix[2:0]);
            vga_hs      <= ~hs_act;
            vga_vs      <= ~vs_act;
            vga_blank_n <= vis;
            vblank      <= (vcnt >= CW'(V_ACTIVE));
            frame_start <= (hcnt == '0) && (vcnt == '0);
        end
    end

endmodule

// File: tb/tb_vga_out.sv
// Directed bench: full-timing instance for line-level/pixel checks, short-frame red-border
// instance for whole-frame sync/blank accounting.
module tb_vga_out;

    localparam int FRAME_S = 800 * 12;

    logic       clk;
    logic       rst;
    logic [7:0] d_px, d_py, d_r, d_g, d_b;
    logic [8:0] d_rgb;
    logic       d_hs, d_vs, d_blank_n, d_vblank, d_fs;
    logic [7:0] s_px, s_py, s_r, s_g, s_b;
    logic [8:0] s_rgb;
    logic       s_hs, s_vs, s_blank_n, s_vblank, s_fs;

    int n_cmp = 0;
    int n_err = 0;
    int opos  = -1;
    bit mon_en = 1'b0;

    vga_out u_dut (
        .clk(clk), .rst(rst), .pix_ptr_x(d_px), .pix_ptr_y(d_py), .rgb(d_rgb),
        .vga_r(d_r), .vga_g(d_g), .vga_b(d_b), .vga_hs(d_hs), .vga_vs(d_vs),
        .vga_blank_n(d_blank_n), .vblank(d_vblank), .frame_start(d_fs)
    );

    vga_out #(
        .V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(4), .BORDER_RGB(9'h1C0)
    ) u_dut_small (
        .clk(clk), .rst(rst), .pix_ptr_x(s_px), .pix_ptr_y(s_py), .rgb(s_rgb),
        .vga_r(s_r), .vga_g(s_g), .vga_b(s_b), .vga_hs(s_hs), .vga_vs(s_vs),
        .vga_blank_n(s_blank_n), .vblank(s_vblank), .frame_start(s_fs)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Frame buffer model: white at (0,0), test colour on rows >= 1, black elsewhere on row 0.
    always_comb begin
        if (d_px == 8'd0 && d_py == 8'd0) d_rgb = 9'h1FF;
        else if (d_py >= 8'd1)            d_rgb = 9'b100_010_001;
        else                              d_rgb = 9'h000;
    end
    assign s_rgb = 9'h1FF;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        opos++;
        mon_en = (opos >= 0) && (opos < FRAME_S);
    endtask

    task automatic goto(input int target);
        while (opos < target) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        opos = -1;
        mon_en = 1'b0;
    endtask

    // Whole-window accounting, sampled on the falling edge.
    int   s_fs_cnt = 0, s_hs_fall = 0, s_hs_low = 0, s_vs_fall = 0, s_vs_low = 0;
    int   s_vb_cnt = 0, s_red = 0, s_white = 0, s_dirty = 0, s_vb_col = 0;
    int   d_fs_cnt = 0, d_blank_l0 = 0, d_hs_first = -1, d_line1 = -1, d_vs_fall = 0;
    logic s_hs_prev = 1'b1, s_vs_prev = 1'b1, d_hs_prev = 1'b1, d_vs_prev = 1'b1, d_bl_prev = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (s_fs) s_fs_cnt++;
            if (!s_hs) s_hs_low++;
            if (s_hs_prev && !s_hs) s_hs_fall++;
            if (!s_vs) s_vs_low++;
            if (s_vs_prev && !s_vs) s_vs_fall++;
            if (s_vblank) s_vb_cnt++;
            if ({s_r, s_g, s_b} == 24'hFF0000) s_red++;
            if ({s_r, s_g, s_b} == 24'hFFFFFF) s_white++;
            if (!s_blank_n && {s_r, s_g, s_b} != 24'h0) s_dirty++;
            if (s_vblank && {s_r, s_g, s_b} != 24'h0) s_vb_col++;
            if (d_fs) d_fs_cnt++;
            if (opos < 800 && d_blank_n) d_blank_l0++;
            if (d_hs_first < 0 && d_hs_prev && !d_hs) d_hs_first = opos;
            if (d_line1 < 0 && opos > 0 && !d_bl_prev && d_blank_n) d_line1 = opos;
            if (d_vs_prev && !d_vs) d_vs_fall++;
            s_hs_prev = s_hs;
            s_vs_prev = s_vs;
            d_hs_prev = d_hs;
            d_vs_prev = d_vs;
            d_bl_prev = d_blank_n;
        end
    end

    initial begin
        rst = 1'b1;
        do_reset();
        check("rst_hs", 32'(d_hs), 32'd1);
        check("rst_vs", 32'(d_vs), 32'd1);
        check("rst_blank_n", 32'(d_blank_n), 32'd0);
        check("rst_vblank", 32'(d_vblank), 32'd0);
        check("rst_fs", 32'(d_fs), 32'd0);
        check("rst_rgb", 32'({d_r, d_g, d_b}), 32'h0);
        check("rst_small_rgb", 32'({s_r, s_g, s_b}), 32'h0);
        check("rst_small_fs", 32'(s_fs), 32'd0);

        tick();
        check("p00_fs", 32'(d_fs), 32'd1);
        check("p00_blank_n", 32'(d_blank_n), 32'd1);
        check("p00_rgb", 32'({d_r, d_g, d_b}), 32'h0);
        check("p00_small_rgb", 32'({s_r, s_g, s_b}), 32'hFF0000);
        check("p00_small_fs", 32'(s_fs), 32'd1);

        goto(63);        check("l0_h63", 32'({d_r, d_g, d_b}), 32'h000000);
        goto(64);        check("l0_h64", 32'({d_r, d_g, d_b}), 32'hFFFFFF);
        goto(65);        check("l0_h65", 32'({d_r, d_g, d_b}), 32'hFFFFFF);
        goto(66);        check("l0_h66", 32'({d_r, d_g, d_b}), 32'h000000);
        goto(800 + 63);  check("l1_h63", 32'({d_r, d_g, d_b}), 32'h000000);
        goto(800 + 64);  check("l1_h64", 32'({d_r, d_g, d_b}), 32'hFFFFFF);
        goto(800 + 65);  check("l1_h65", 32'({d_r, d_g, d_b}), 32'hFFFFFF);
        goto(800 + 66);  check("l1_h66", 32'({d_r, d_g, d_b}), 32'h000000);
        goto(1600 + 64); check("l2_h64", 32'({d_r, d_g, d_b}), 32'h924924);
        // pix_ptr reflects stage 0, one position ahead of the registered outputs.
        goto(1600 + 65); check("ptrx_h66", 32'(d_px), 32'd1);
                         check("ptry_l2", 32'(d_py), 32'd1);
        goto(1600 + 573); check("ptrx_h574", 32'(d_px), 32'd255);
        goto(1600 + 574); check("ptrx_h575", 32'(d_px), 32'd255);
                          check("l2_h574", 32'({d_r, d_g, d_b}), 32'h924924);
        goto(1600 + 575); check("ptrx_h576", 32'(d_px), 32'd0);
                          check("ptry_h576", 32'(d_py), 32'd0);
                          check("l2_h575", 32'({d_r, d_g, d_b}), 32'h924924);
        goto(1600 + 576); check("l2_h576", 32'({d_r, d_g, d_b}), 32'h000000);

        goto(2400 + 640); check("s_l3_h640_rgb", 32'({s_r, s_g, s_b}), 32'h0);
                          check("s_l3_h640_blank", 32'(s_blank_n), 32'd0);
        goto(3200 + 10);  check("s_l4_vblank", 32'(s_vblank), 32'd1);
                          check("s_l4_rgb", 32'({s_r, s_g, s_b}), 32'h0);

        goto(FRAME_S);
        check("s_fs_count", 32'(s_fs_cnt), 32'd1);
        check("s_hs_pulses", 32'(s_hs_fall), 32'd12);
        check("s_hs_low_cycles", 32'(s_hs_low), 32'd1152);
        check("s_vs_pulses", 32'(s_vs_fall), 32'd1);
        check("s_vs_low_cycles", 32'(s_vs_low), 32'd1600);
        check("s_vblank_cycles", 32'(s_vb_cnt), 32'd6400);
        check("s_red_border", 32'(s_red), 32'd512);
        check("s_white_img", 32'(s_white), 32'd2048);
        check("s_blank_colour", 32'(s_dirty), 32'd0);
        check("s_vblank_colour", 32'(s_vb_col), 32'd0);
        check("d_fs_count", 32'(d_fs_cnt), 32'd1);
        check("d_blank_line0", 32'(d_blank_l0), 32'd640);
        check("d_hs_fall_pos", 32'(d_hs_first), 32'd656);
        check("d_line1_start", 32'(d_line1), 32'd800);
        check("d_vs_pulses", 32'(d_vs_fall), 32'd0);

        // Mid-line reset: stage 0 sits at line 13, hcnt 300 when rst is sampled.
        goto(13 * 800 + 299);
        do_reset();
        check("mrst_hs", 32'(d_hs), 32'd1);
        check("mrst_blank_n", 32'(d_blank_n), 32'd0);
        check("mrst_fs", 32'(d_fs), 32'd0);
        check("mrst_rgb", 32'({d_r, d_g, d_b}), 32'h0);
        check("mrst_ptrx", 32'(d_px), 32'd0);
        check("mrst_small_vblank", 32'(s_vblank), 32'd0);
        tick();
        check("mrst_fs_next", 32'(d_fs), 32'd1);
        check("mrst_small_fs_next", 32'(s_fs), 32'd1);
        check("mrst_small_rgb", 32'({s_r, s_g, s_b}), 32'hFF0000);
        tick();
        check("mrst_fs_drop", 32'(d_fs), 32'd0);
        goto(64);  check("mrst_h64", 32'({d_r, d_g, d_b}), 32'hFFFFFF);
                   check("mrst_small_h64", 32'({s_r, s_g, s_b}), 32'hFFFFFF);
        goto(655); check("mrst_hs655", 32'(d_hs), 32'd1);
        goto(656); check("mrst_hs656", 32'(d_hs), 32'd0);
        goto(800); check("mrst_l1_blank", 32'(d_blank_n), 32'd1);
                   check("mrst_l1_vs", 32'(d_vs), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
